cacheline_arbiter: RTL and testbench

- Sits directly downstream of the instruction cache and the data cache.
- Merges their 256-bit cacheline miss/writeback requests onto the single physical-memory port.
- Grants one requester at a time and latches that requester's address, command and write data.
- Routes the memory response and read line back only to the granted cache; ties are broken round-robin.

---
 rtl/cacheline_arbiter.sv | 124 ++++++++++++
 tb/tb_cacheline_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cacheline_arbiter
//  Purpose  : Round-robin merge of icache/dcache line requests onto one pmem port
//  Revision : 1.0
// ============================================================================
module cacheline_arbiter #(
    parameter int S_LINE = 256,
    parameter int S_ADDR = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [S_ADDR-1:0] i_pmem_address,
    input  logic              i_pmem_read,
    output logic [S_LINE-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic [S_ADDR-1:0] d_pmem_address,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [S_LINE-1:0] d_pmem_wdata,
    output logic [S_LINE-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic [S_ADDR-1:0] pmem_address,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [S_LINE-1:0] pmem_wdata,
    input  logic [S_LINE-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [S_ADDR-1:0] addr_q, addr_d;
    logic [S_LINE-1:0] wdata_q, wdata_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;

    logic w_i_req;
    logic w_d_req;
    logic w_grant_d;
    logic w_serving;

    assign w_i_req   = i_pmem_read;
    assign w_d_req   = d_pmem_read | d_pmem_write;
    // dcache wins when alone, or on a tie when icache held the last grant
    assign w_grant_d = w_d_req & (~w_i_req | ~last_grant_q);
    assign w_serving = (state_q != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        case (state_q)
            IDLE: begin
                if (w_grant_d) begin
                    state_d      = SERVE_D;
                    last_grant_d = 1'b1;
                    addr_d       = d_pmem_address;
                    wdata_d      = d_pmem_wdata;
                    // a simultaneous read+write is executed as a writeback only
                    rd_d         = d_pmem_read & ~d_pmem_write;
                    wr_d         = d_pmem_write;
                end else if (w_i_req) begin
                    state_d      = SERVE_I;
                    last_grant_d = 1'b0;
                    addr_d       = i_pmem_address;
                    rd_d         = 1'b1;
                    wr_d         = 1'b0;
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) begin
                    state_d = IDLE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end
        endcase
    end

    assign pmem_address = w_serving ? addr_q  : '0;
    assign pmem_wdata   = w_serving ? wdata_q : '0;
    assign pmem_read    = w_serving & rd_q;
    assign pmem_write   = w_serving & wr_q;

    assign i_pmem_resp  = (state_q == SERVE_I) & pmem_resp;
    assign d_pmem_resp  = (state_q == SERVE_D) & pmem_resp;
    assign i_pmem_rdata = i_pmem_resp ? pmem_rdata : '0;
    assign d_pmem_rdata = d_pmem_resp ? pmem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_cacheline_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cacheline_arbiter
//  Purpose  : Scoreboard bench for cacheline_arbiter against a transaction model
//  Revision : 1.0
// ============================================================================
module tb_cacheline_arbiter;

    localparam int S_LINE = 256;
    localparam int S_ADDR = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [S_ADDR-1:0] i_pmem_address;
    logic              i_pmem_read;
    logic [S_LINE-1:0] i_pmem_rdata;
    logic              i_pmem_resp;
    logic [S_ADDR-1:0] d_pmem_address;
    logic              d_pmem_read;
    logic              d_pmem_write;
    logic [S_LINE-1:0] d_pmem_wdata;
    logic [S_LINE-1:0] d_pmem_rdata;
    logic              d_pmem_resp;
    logic [S_ADDR-1:0] pmem_address;
    logic              pmem_read;
    logic              pmem_write;
    logic [S_LINE-1:0] pmem_wdata;
    logic [S_LINE-1:0] pmem_rdata;
    logic              pmem_resp;

    cacheline_arbiter #(.S_LINE(S_LINE), .S_ADDR(S_ADDR)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_address (i_pmem_address),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_address (d_pmem_address),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .pmem_address   (pmem_address),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  addr;
        logic         rd;
        logic         wr;
        logic [255:0] wdata;
        bit           side;   // 0 = icache, 1 = dcache
    } cmd_t;

    typedef struct {
        bit           side;
        logic [255:0] data;
    } rsp_t;

    cmd_t exp_cmd_q[$];
    rsp_t exp_rsp_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // transaction-level model of both caches, the memory and the arbitration rule
    bit           i_pend, d_pend;
    logic [31:0]  i_addr_m, d_addr_m;
    logic         d_rd_m, d_wr_m;
    logic [255:0] d_wdata_m;
    bit           m_busy, m_side, m_last;
    int           m_wait;
    bit           clr_valid, clr_side;
    int           n_done = 0;

    int           req_pct = 0;
    int           stray_pct = 0;
    int           lat_fix = -1;
    bit           perturb = 0;
    bit           rdata_fix_en = 0;
    logic [255:0] rdata_fix = '0;

    task automatic drive_zero();
        i_pmem_address = '0; i_pmem_read = 1'b0;
        d_pmem_address = '0; d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_wdata = '0;
        pmem_resp = 1'b0; pmem_rdata = '0;
    endtask

    task automatic model_clear();
        i_pend = 0; d_pend = 0; m_busy = 0; m_side = 0; m_last = 0;
        m_wait = 0; clr_valid = 0; clr_side = 0;
        exp_cmd_q.delete();
        exp_rsp_q.delete();
        drive_zero();
    endtask

    task automatic req_i(input logic [31:0] a);
        i_pend = 1; i_addr_m = a;
    endtask

    task automatic req_d(input logic [31:0] a, input logic rd, input logic wr, input logic [255:0] wd);
        d_pend = 1; d_addr_m = a; d_rd_m = rd; d_wr_m = wr; d_wdata_m = wd;
    endtask

    task automatic step();
        cmd_t c;
        rsp_t r;
        bit   gd;
        @(negedge clk);
        if (clr_valid) begin
            if (clr_side) d_pend = 0; else i_pend = 0;
            clr_valid = 0;
        end
        if (!i_pend && $urandom_range(99) < req_pct) req_i($urandom & 32'hFFFF_FFE0);
        if (!d_pend && $urandom_range(99) < req_pct) begin
            case ($urandom_range(2))
                0:       req_d($urandom & 32'hFFFF_FFE0, 1'b1, 1'b0, rand_line());
                1:       req_d($urandom & 32'hFFFF_FFE0, 1'b0, 1'b1, rand_line());
                default: req_d($urandom & 32'hFFFF_FFE0, 1'b1, 1'b1, rand_line());
            endcase
        end
        i_pmem_read    = i_pend;
        i_pmem_address = i_addr_m;
        d_pmem_read    = d_pend & d_rd_m;
        d_pmem_write   = d_pend & d_wr_m;
        d_pmem_address = d_addr_m;
        d_pmem_wdata   = d_wdata_m;
        pmem_resp      = 1'b0;
        pmem_rdata     = rand_line();
        if (m_busy) begin
            // the requester being served may wiggle or drop its lines freely
            if (perturb && $urandom_range(1) == 1) begin
                if (m_side) begin
                    d_pmem_address = $urandom;
                    d_pmem_wdata   = rand_line();
                    d_pmem_read    = 1'($urandom_range(1));
                    d_pmem_write   = 1'($urandom_range(1));
                end else begin
                    i_pmem_address = $urandom;
                    i_pmem_read    = 1'($urandom_range(1));
                end
            end
            if (m_wait == 0) begin
                pmem_resp = 1'b1;
                if (rdata_fix_en) pmem_rdata = rdata_fix;
                r.side = m_side;
                r.data = pmem_rdata;
                exp_rsp_q.push_back(r);
                m_busy = 0; clr_valid = 1; clr_side = m_side;
                n_done++;
            end else begin
                m_wait--;
            end
        end else begin
            if ($urandom_range(99) < stray_pct) pmem_resp = 1'b1;
            if (i_pend || d_pend) begin
                gd = d_pend && (!i_pend || m_last == 0);
                c.side  = gd;
                c.addr  = gd ? d_addr_m : i_addr_m;
                c.rd    = gd ? (d_rd_m & ~d_wr_m) : 1'b1;
                c.wr    = gd ? d_wr_m : 1'b0;
                c.wdata = d_wdata_m;
                exp_cmd_q.push_back(c);
                m_busy = 1; m_side = gd; m_last = gd;
                m_wait = (lat_fix >= 0) ? lat_fix : int'($urandom_range(5));
            end
        end
    endtask

    task automatic run_until_idle(input string nm);
        int k;
        for (k = 0; k < 80 && (m_busy || i_pend || d_pend || clr_valid); k++) step();
        checks++;
        if (m_busy || i_pend || d_pend || clr_valid) begin
            errors++;
            $display("FAIL %s_timeout actual=busy required=idle", nm);
        end
        step();
    endtask

    task automatic async_reset(input bit mid_serve_d);
        @(negedge clk);
        #2;
        if (mid_serve_d) begin
            chk("serve_d_write_before_rst", 256'(pmem_write), 256'(1));
            pmem_resp  = 1'b1;
            pmem_rdata = rand_line();
        end
        rst = 1'b1;
        #1;
        chk("rst_pmem_read",    256'(pmem_read),    256'(0));
        chk("rst_pmem_write",   256'(pmem_write),   256'(0));
        chk("rst_pmem_address", 256'(pmem_address), 256'(0));
        chk("rst_pmem_wdata",   pmem_wdata,         256'(0));
        chk("rst_i_resp",       256'(i_pmem_resp),  256'(0));
        chk("rst_d_resp",       256'(d_pmem_resp),  256'(0));
        chk("rst_i_rdata",      i_pmem_rdata,       256'(0));
        chk("rst_d_rdata",      d_pmem_rdata,       256'(0));
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // monitor: pops expectations whenever the DUT shows a command or response
    bit   mon_en = 0;
    bit   prev_cmd = 0, prev_resp = 0;
    int   pend_prev = 0;
    cmd_t cur;
    rsp_t rr;

    initial begin
        logic cmd;
        forever begin
            @(negedge clk);
            #4;
            if (rst || !mon_en) begin
                prev_cmd = 0; prev_resp = 0; pend_prev = 0;
                continue;
            end
            cmd = pmem_read | pmem_write;
            if (prev_resp) chk("dead_cycle", 256'(cmd), 256'(0));
            if (cmd && !prev_cmd) begin
                if (exp_cmd_q.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL cmd_unexpected actual=addr %h required=no command", pmem_address);
                end else begin
                    cur = exp_cmd_q.pop_front();
                    chk("cmd_addr",  256'(pmem_address), 256'(cur.addr));
                    chk("cmd_read",  256'(pmem_read),    256'(cur.rd));
                    chk("cmd_write", 256'(pmem_write),   256'(cur.wr));
                    if (cur.side) chk("cmd_wdata", pmem_wdata, cur.wdata);
                end
            end else if (cmd) begin
                chk("hold_addr",  256'(pmem_address), 256'(cur.addr));
                chk("hold_read",  256'(pmem_read),    256'(cur.rd));
                chk("hold_write", 256'(pmem_write),   256'(cur.wr));
                if (cur.side) chk("hold_wdata", pmem_wdata, cur.wdata);
            end else begin
                chk("idle_addr",  256'(pmem_address), 256'(0));
                chk("idle_wdata", pmem_wdata,         256'(0));
                if (pend_prev > 0) begin
                    errors++; checks++;
                    $display("FAIL cmd_missing actual=no command required=addr %h", exp_cmd_q[0].addr);
                    void'(exp_cmd_q.pop_front());
                end
            end
            if (exp_rsp_q.size() > 0) begin
                rr = exp_rsp_q.pop_front();
                chk("i_resp",  256'(i_pmem_resp), 256'(rr.side == 0));
                chk("d_resp",  256'(d_pmem_resp), 256'(rr.side == 1));
                chk("i_rdata", i_pmem_rdata, rr.side ? 256'(0) : rr.data);
                chk("d_rdata", d_pmem_rdata, rr.side ? rr.data : 256'(0));
            end else begin
                chk("i_resp_quiet",  256'(i_pmem_resp), 256'(0));
                chk("d_resp_quiet",  256'(d_pmem_resp), 256'(0));
                chk("i_rdata_quiet", i_pmem_rdata, 256'(0));
                chk("d_rdata_quiet", d_pmem_rdata, 256'(0));
            end
            prev_cmd  = cmd;
            prev_resp = i_pmem_resp | d_pmem_resp;
            pend_prev = exp_cmd_q.size();
        end
    end

    initial begin
        int start;
        model_clear();
        repeat (2) @(negedge clk);
        async_reset(1'b0);
        mon_en = 1;

        // lone icache read, fixed 5-cycle memory latency and known line
        lat_fix = 4; rdata_fix_en = 1; rdata_fix = {8{32'hDEADBEEF}};
        req_i(32'h0000_1A20);
        run_until_idle("lone_icache");
        rdata_fix_en = 0;

        // tie right after reset goes to dcache, then icache after a dead cycle
        async_reset(1'b0);
        lat_fix = -1;
        req_i(32'h0000_0100);
        req_d(32'h0000_0200, 1'b0, 1'b1, {8{32'hA5A5A5A5}});
        run_until_idle("tie_after_reset");

        // both caches requesting continuously: grants must alternate
        req_pct = 100;
        start = n_done;
        for (int k = 0; k < 200 && n_done < start + 6; k++) step();
        chk("continuous_six", 256'(n_done - start >= 6), 256'(1));
        req_pct = 0;
        run_until_idle("continuous");

        // read+write together is a write; wiggled inputs are ignored
        lat_fix = 3; perturb = 1;
        req_d(32'h0000_0300, 1'b1, 1'b1, rand_line());
        run_until_idle("rdwr_0x300");
        perturb = 0; lat_fix = -1;

        // stray responses while idle
        stray_pct = 100;
        repeat (5) step();
        stray_pct = 0;
        req_i(32'h0000_0500);
        run_until_idle("after_stray");

        // reset in the middle of a dcache writeback
        lat_fix = 8;
        req_d(32'h0000_0400, 1'b0, 1'b1, rand_line());
        for (int k = 0; k < 10 && !m_busy; k++) step();
        step();
        async_reset(1'b1);
        lat_fix = -1;
        req_i(32'h0000_0600);
        req_d(32'h0000_0700, 1'b1, 1'b0, rand_line());
        run_until_idle("tie_after_mid_reset");

        // randomized traffic
        req_pct = 40; stray_pct = 10; perturb = 1;
        repeat (400) step();
        req_pct = 0; stray_pct = 0; perturb = 0;
        run_until_idle("random_drain");
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
